// File: rtl/pwc_pkg.sv
// Shared definitions for the pattern window counter.
// Holds the report-slot FSM state encoding and the default window geometry
// used by pattern_window_counter and pwc_report_slot.
package pwc_pkg;

  localparam int unsigned PWC_WINDOW_LEN_DEFAULT = 16;
  localparam int unsigned PWC_CNT_W_DEFAULT      = 8;
  localparam int unsigned PWC_SEQ_W              = 8;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } pwc_state_t;

endpackage

// File: rtl/pwc_report_slot.sv
// Single-entry report holding register with its EMPTY/FULL FSM.
//   clk          : clock, all logic on posedge
//   reset        : synchronous, active-low
//   load         : a window has just closed; load_count/load_seq describe it
//   load_count   : pattern count of the closing window
//   load_seq     : sequence number of the closing window
//   report_ready : consumer accepts the held report when report_valid is high
//   report_valid : a report is held (registered, straight from the FSM state)
//   report_count : held pattern count
//   report_seq   : held window sequence number
//   overrun      : sticky; a closed window arrived while the slot was full
//                  and not being drained, and was dropped
module pwc_report_slot
  import pwc_pkg::*;
#(
  parameter int unsigned CNT_W = PWC_CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_W-1:0]     load_count,
  input  logic [PWC_SEQ_W-1:0] load_seq,
  input  logic                 report_ready,
  output logic                 report_valid,
  output logic [CNT_W-1:0]     report_count,
  output logic [PWC_SEQ_W-1:0] report_seq,
  output logic                 overrun
);

  pwc_state_t state, state_nxt;
  logic       take;
  logic       drop;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    drop      = 1'b0;
    case (state)
      S_EMPTY: begin
        if (load) begin
          state_nxt = S_FULL;
          take      = 1'b1;
        end
      end
      S_FULL: begin
        if (load) begin
          // Slot stays full: either the held report is consumed this cycle
          // and replaced, or the new one is dropped.
          state_nxt = S_FULL;
          if (report_ready) take = 1'b1;
          else              drop = 1'b1;
        end else if (report_ready) begin
          state_nxt = S_EMPTY;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_EMPTY;
      report_count <= '0;
      report_seq   <= '0;
      overrun      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        report_count <= load_count;
        report_seq   <= load_seq;
      end
      if (drop) overrun <= 1'b1;
    end
  end

  assign report_valid = (state == S_FULL);

endmodule

// File: rtl/pattern_window_counter.sv
// Counts pattern-detector pulses over fixed windows of WINDOW_LEN vehicles
// and hands each window's count to a consumer through a one-entry slot.
//   clk          : clock, all logic on posedge
//   reset        : synchronous, active-low
//   valid_in     : vehicle strobe
//   pattern_flag : pattern pulse, one cycle after the completing valid_in
//   report_valid : window report held and available
//   report_ready : consumer accepts report when high with report_valid
//   report_count : pattern count of the reported window (CNT_W bits)
//   report_seq   : window sequence number, wraps 255->0
//   overrun      : sticky; a completed window report was dropped
// Build option: define PWC_SATURATE_EN to saturate the window count at
// 2^CNT_W-1 instead of wrapping.
module pattern_window_counter
  import pwc_pkg::*;
#(
  parameter int unsigned WINDOW_LEN = PWC_WINDOW_LEN_DEFAULT,
  parameter int unsigned CNT_W      = PWC_CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 pattern_flag,
  output logic                 report_valid,
  input  logic                 report_ready,
  output logic [CNT_W-1:0]     report_count,
  output logic [PWC_SEQ_W-1:0] report_seq,
  output logic                 overrun
);

  localparam logic [7:0] LAST_VEH = 8'(WINDOW_LEN - 1);

  logic [7:0]           veh_cnt;
  logic                 close_pend;
  logic [CNT_W-1:0]     win_cnt;
  logic [CNT_W-1:0]     win_inc;
  logic [CNT_W-1:0]     close_count;
  logic [PWC_SEQ_W-1:0] win_idx;

  always_comb begin
`ifdef PWC_SATURATE_EN
    win_inc = (win_cnt == '1) ? win_cnt : win_cnt + CNT_W'(1);
`else
    win_inc = win_cnt + CNT_W'(1);
`endif
  end

  // The pulse for the last vehicle lands in the close_pend cycle, so it is
  // folded into the report here rather than into win_cnt.
  assign close_count = pattern_flag ? win_inc : win_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      veh_cnt    <= '0;
      close_pend <= 1'b0;
      win_cnt    <= '0;
      win_idx    <= '0;
    end else begin
      close_pend <= 1'b0;
      // veh_cnt is already 0 during close_pend, so a strobe there naturally
      // becomes vehicle 1 of the next window.
      if (valid_in) begin
        if (veh_cnt == LAST_VEH) begin
          veh_cnt    <= '0;
          close_pend <= 1'b1;
        end else begin
          veh_cnt <= veh_cnt + 8'd1;
        end
      end
      if (close_pend) begin
        win_cnt <= '0;
        win_idx <= win_idx + PWC_SEQ_W'(1);
      end else if (pattern_flag) begin
        win_cnt <= win_inc;
      end
    end
  end

  pwc_report_slot #(
    .CNT_W(CNT_W)
  ) u_slot (
    .clk          (clk),
    .reset        (reset),
    .load         (close_pend),
    .load_count   (close_count),
    .load_seq     (win_idx),
    .report_ready (report_ready),
    .report_valid (report_valid),
    .report_count (report_count),
    .report_seq   (report_seq),
    .overrun      (overrun)
  );

endmodule

// File: tb/tb_pattern_window_counter.sv
module tb_pattern_window_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic       pattern_flag;
  logic       report_valid;
  logic       report_ready;
  logic [1:0] report_count;
  logic [7:0] report_seq;
  logic       overrun;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    int unsigned cnt;
    int unsigned seq;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int unsigned sat_exp;

  pattern_window_counter #(
    .WINDOW_LEN(4),
    .CNT_W     (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .pattern_flag (pattern_flag),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .report_count (report_count),
    .report_seq   (report_seq),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic p);
    valid_in     = v;
    pattern_flag = p;
    @(posedge clk);
    #1;
    valid_in     = 1'b0;
    pattern_flag = 1'b0;
  endtask

  task automatic push(input int unsigned c, input int unsigned s);
    exp_t e;
    e.cnt = c;
    e.seq = s;
    sb.push_back(e);
  endtask

  // Scoreboard: every handshake (valid & ready) consumes one expected report.
  always @(negedge clk) begin
    if (reset && report_valid && report_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_report", 32'(report_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("sb_count", 32'(report_count), mon_e.cnt);
        check_eq("sb_seq", 32'(report_seq), mon_e.seq);
      end
    end
  end

  initial begin
    reset        = 1'b0;
    valid_in     = 1'b0;
    pattern_flag = 1'b0;
    report_ready = 1'b0;
    step(0, 0);
    step(0, 0);
    check_eq("rst_valid", 32'(report_valid), 0);
    check_eq("rst_count", 32'(report_count), 0);
    check_eq("rst_seq", 32'(report_seq), 0);
    check_eq("rst_overrun", 32'(overrun), 0);
    reset = 1'b1;

    // Basic window, pulse in close cycle, one-cycle report.
    report_ready = 1'b1;
    push(2, 0);
    step(1, 0); step(1, 0); step(1, 1); step(1, 0);
    check_eq("A_latency", 32'(report_valid), 0);
    step(0, 1);
    check_eq("A_valid", 32'(report_valid), 1);
    check_eq("A_count", 32'(report_count), 2);
    check_eq("A_seq", 32'(report_seq), 0);
    step(0, 0);
    check_eq("A_one_cycle", 32'(report_valid), 0);

    // Strobe in close cycle counts toward the next window.
    push(0, 1);
    push(1, 2);
    step(1, 0); step(1, 0); step(1, 0); step(1, 0);
    step(1, 0);
    check_eq("B_valid_w1", 32'(report_valid), 1);
    step(1, 1);
    check_eq("B_drained", 32'(report_valid), 0);
    step(1, 0);
    step(1, 0);
    check_eq("B_latency", 32'(report_valid), 0);
    step(0, 0);
    check_eq("B_early_close", 32'(report_valid), 1);
    step(0, 0);
    check_eq("B_done", 32'(report_valid), 0);

    // Close in S_FULL with ready: replace without overrun; hold stability.
    report_ready = 1'b0;
    push(1, 3);
    push(2, 4);
    step(1, 0); step(1, 0); step(1, 0); step(1, 1);
    step(0, 0);
    check_eq("C_valid", 32'(report_valid), 1);
    check_eq("C_count", 32'(report_count), 1);
    check_eq("C_seq", 32'(report_seq), 3);
    step(1, 1);
    check_eq("C_hold_count", 32'(report_count), 1);
    check_eq("C_hold_seq", 32'(report_seq), 3);
    step(1, 0); step(1, 1); step(1, 0);
    check_eq("C_hold_valid", 32'(report_valid), 1);
    check_eq("C_hold_count2", 32'(report_count), 1);
    report_ready = 1'b1;
    step(0, 0);
    check_eq("C_swap_valid", 32'(report_valid), 1);
    check_eq("C_swap_count", 32'(report_count), 2);
    check_eq("C_swap_seq", 32'(report_seq), 4);
    check_eq("C_no_overrun", 32'(overrun), 0);
    step(0, 0);
    check_eq("C_done", 32'(report_valid), 0);

    // Two closes while stalled: first held, second dropped, seq advances.
    report_ready = 1'b0;
    push(1, 5);
    push(0, 7);
    step(1, 0); step(1, 0); step(1, 1); step(1, 0);
    step(0, 0);
    step(1, 1); step(1, 1); step(1, 0); step(1, 0);
    step(0, 1);
    check_eq("D_valid", 32'(report_valid), 1);
    check_eq("D_held_count", 32'(report_count), 1);
    check_eq("D_held_seq", 32'(report_seq), 5);
    check_eq("D_overrun", 32'(overrun), 1);
    report_ready = 1'b1;
    step(0, 0);
    check_eq("D_drained", 32'(report_valid), 0);
    step(1, 0); step(1, 0); step(1, 0); step(1, 0);
    step(0, 0);
    check_eq("D_next_valid", 32'(report_valid), 1);
    check_eq("D_next_seq", 32'(report_seq), 7);
    check_eq("D_overrun_sticky", 32'(overrun), 1);
    step(0, 0);
    check_eq("D_done", 32'(report_valid), 0);

    // Five pulses into a 2-bit count.
`ifdef PWC_SATURATE_EN
    sat_exp = 3;
`else
    sat_exp = 1;
`endif
    push(sat_exp, 8);
    step(1, 1); step(1, 1); step(1, 1); step(0, 1); step(1, 1);
    step(0, 0);
    check_eq("E_valid", 32'(report_valid), 1);
    check_eq("E_count", 32'(report_count), sat_exp);
    step(0, 0);
    check_eq("E_done", 32'(report_valid), 0);

    // Reset mid-window discards the partial window.
    step(1, 1); step(1, 0); step(1, 0);
    reset = 1'b0;
    step(0, 0);
    check_eq("F_rst_valid", 32'(report_valid), 0);
    check_eq("F_rst_count", 32'(report_count), 0);
    check_eq("F_rst_seq", 32'(report_seq), 0);
    check_eq("F_rst_overrun", 32'(overrun), 0);
    reset = 1'b1;
    push(1, 0);
    step(1, 1);
    check_eq("F_fresh1", 32'(report_valid), 0);
    step(1, 0);
    check_eq("F_fresh2", 32'(report_valid), 0);
    step(1, 0);
    check_eq("F_fresh3", 32'(report_valid), 0);
    step(0, 0);
    check_eq("F_fresh4", 32'(report_valid), 0);
    step(1, 0);
    step(0, 0);
    check_eq("F_valid", 32'(report_valid), 1);
    check_eq("F_count", 32'(report_count), 1);
    check_eq("F_seq", 32'(report_seq), 0);
    step(0, 0);
    check_eq("F_done", 32'(report_valid), 0);

    step(0, 0);
    check_eq("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
